n101_qspi_fifo_gen2: RTL
========================

N101_QSPI_FIFO_GEN2 -- requirements
Module: n101_qspi_fifo_gen2

Interface
REQ-001 SHALL provide parameter DW, default 8, link/bus data width in bits.
REQ-002 SHALL provide parameter TXD, default 8, TX FIFO depth (power of two, >=2).
REQ-003 SHALL provide parameter RXD, default 8, RX FIFO depth (power of two, >=2).
REQ-004 SHALL provide parameter LW, default 4, frame-length field width; CW = clog2(max(TXD,RXD))+1.
REQ-005 SHALL provide ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- io_ctrl_fmt_proto  in  2  0 single, 1 dual, 2 quad, 3 reserved.
- io_ctrl_fmt_iodir  in  1  0 = receive during TX frame.
- io_ctrl_fmt_len  in  LW  bits per frame.
- io_ctrl_cs_mode  in  2  0/1 auto, 2 hold, 3 off.
- io_ctrl_wm_tx  in  CW  TX watermark.
- io_ctrl_wm_rx  in  CW  RX watermark.
- io_flush_tx  in  1  synchronous TX FIFO flush.
- io_flush_rx  in  1  synchronous RX FIFO flush.
- io_tx_valid / io_tx_ready / io_tx_bits  in / out / in  1/1/DW  bus-side TX enqueue.
- io_rx_valid / io_rx_ready / io_rx_bits  out / in / out  1/1/DW  bus-side RX dequeue.
- io_link_tx_valid / io_link_tx_ready / io_link_tx_bits  out / in / out  1/1/DW  TX to shifter.
- io_link_rx_valid / io_link_rx_bits  in / in  1/DW  RX from shifter, no backpressure.
- io_link_cnt  out  LW  shifter cycles per frame.
- io_link_cs_set / io_link_cs_clear / io_link_lock  out  1 each  chip-select and lock controls.
- io_ip_txwm / io_ip_rxwm  out  1 each  watermark interrupt-pending.
- io_rx_ovf  out  1  sticky RX overflow flag.

Function
REQ-006 TX FIFO SHALL be a TXD-entry circular buffer: enqueue on io_tx_valid&io_tx_ready; io_tx_ready = (txcount<TXD); io_link_tx_valid = (txcount!=0); io_link_tx_bits = head entry; dequeue on io_link_tx_valid&io_link_tx_ready (fire_tx).
REQ-007 No bypass: enqueue into empty FIFO SHALL appear on link side the next cycle (latency 1); simultaneous enq+deq SHALL keep count unchanged; pointers SHALL wrap DEPTH-1 -> 0.
REQ-008 RX FIFO SHALL mirror REQ-006/007 (RXD entries), enqueue = io_link_rx_valid & rxen & (rxcount<RXD); an entry arriving while full SHALL be dropped.
REQ-009 rxen register: on fire_tx load (io_ctrl_fmt_iodir==0); else on io_link_rx_valid clear; fire_tx has priority.
REQ-010 io_link_cnt = ceil(len/k), k=1/2/4 for proto 0/1/2; proto 3 gives 0; result truncated to LW bits.
REQ-011 cs_mode register SHALL capture io_ctrl_cs_mode every cycle; io_link_cs_set = (cs_mode!=3); io_link_cs_clear = (cs_mode!=io_ctrl_cs_mode) | (fire_tx & cs_mode in {0,1}).
REQ-012 io_link_lock = io_link_tx_valid | rxen.
REQ-013 io_ip_txwm = (txcount < io_ctrl_wm_tx); io_ip_rxwm = (rxcount > io_ctrl_wm_rx); both combinational from registered counts.
REQ-014 Flush SHALL zero that FIFO's pointers/count on the next edge, overriding a same-cycle enqueue/dequeue; io_flush_rx SHALL also clear rxen.

Reset
REQ-015 On reset_n low: pointers, counts, rxen, cs_mode, io_rx_ovf = 0; thus io_tx_ready=1, io_link_tx_valid=0, io_rx_valid=0, io_link_lock=0, io_link_cs_set=1, io_ip_rxwm=0; storage contents undefined.

Configuration
REQ-016 With N101_QSPI_FIFO_RXOVF_EN defined, io_rx_ovf SHALL set when an RX entry is dropped per REQ-008 and clear only on io_flush_rx or reset; without it io_rx_ovf SHALL be tied 0 and drops are silent.

Verification
REQ-017 Push 0x11..0x18 with link ready low (TXD=8) -> io_tx_ready=0 after 8th, io_link_tx_valid=1, io_ip_txwm=0 with wm_tx=8.
REQ-018 proto=1, len=8 -> io_link_cnt=4; proto=2, len=5 -> 2; proto=3 -> 0.
REQ-019 iodir=0, fire_tx then link_rx_valid with 0xA5 -> rxen 1 then 0, io_rx_bits=0xA5 next cycle, io_link_lock falls.
REQ-020 Fill RX (RXD=8) then one more link_rx_valid -> entry dropped, rxcount=8, io_rx_ovf=1 (macro on) / 0 (macro off); io_flush_rx -> count 0, ovf 0.
REQ-021 cs_mode 0->2 change -> io_link_cs_clear pulses one cycle; cs_mode=3 -> io_link_cs_set=0; reset_n asserted mid-transfer -> all REQ-015 values immediately.

Source files
------------

// File: rtl/n101_qspi_fifo_gen2.sv
// QSPI bus-side TX/RX FIFO pair with frame-length, chip-select and watermark control.
// Optional sticky RX overflow flag enabled by defining N101_QSPI_FIFO_RXOVF_EN.
module n101_qspi_fifo_gen2 #(
    parameter int DW  = 8,
    parameter int TXD = 8,
    parameter int RXD = 8,
    parameter int LW  = 4,
    parameter int CW  = $clog2((TXD > RXD) ? TXD : RXD) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    io_ctrl_fmt_proto,
    input  logic          io_ctrl_fmt_iodir,
    input  logic [LW-1:0] io_ctrl_fmt_len,
    input  logic [1:0]    io_ctrl_cs_mode,
    input  logic [CW-1:0] io_ctrl_wm_tx,
    input  logic [CW-1:0] io_ctrl_wm_rx,
    input  logic          io_flush_tx,
    input  logic          io_flush_rx,
    input  logic          io_tx_valid,
    output logic          io_tx_ready,
    input  logic [DW-1:0] io_tx_bits,
    output logic          io_rx_valid,
    input  logic          io_rx_ready,
    output logic [DW-1:0] io_rx_bits,
    output logic          io_link_tx_valid,
    input  logic          io_link_tx_ready,
    output logic [DW-1:0] io_link_tx_bits,
    input  logic          io_link_rx_valid,
    input  logic [DW-1:0] io_link_rx_bits,
    output logic [LW-1:0] io_link_cnt,
    output logic          io_link_cs_set,
    output logic          io_link_cs_clear,
    output logic          io_link_lock,
    output logic          io_ip_txwm,
    output logic          io_ip_rxwm,
    output logic          io_rx_ovf
);

    localparam int TAW = $clog2(TXD);
    localparam int RAW = $clog2(RXD);
    localparam logic [TAW:0] TX_DEPTH = TXD[TAW:0];
    localparam logic [RAW:0] RX_DEPTH = RXD[RAW:0];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]  tx_mem [TXD];
    logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic           tx_enq, fire_tx;

    assign io_tx_ready      = (tx_cnt_q < TX_DEPTH);
    assign io_link_tx_valid = (tx_cnt_q != '0);
    assign io_link_tx_bits  = tx_mem[tx_rd_q];
    assign tx_enq           = io_tx_valid & io_tx_ready;
    assign fire_tx          = io_link_tx_valid & io_link_tx_ready;

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (io_flush_tx) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_enq)  tx_wr_d = tx_wr_q + TAW'(1);
            if (fire_tx) tx_rd_d = tx_rd_q + TAW'(1);
            case ({tx_enq, fire_tx})
                2'b10:   tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // NOTE: storage arrays are deliberately not reset; validity is tracked
    // by the counts alone, which keeps the arrays mappable to plain RAM.
    always_ff @(posedge clock) begin
        if (tx_enq) tx_mem[tx_wr_q] <= io_tx_bits;
    end

    // ------------------------------------------------------------------
    // RX FIFO and receive-enable
    // ------------------------------------------------------------------
    logic [DW-1:0]  rx_mem [RXD];
    logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;
    logic           rx_enq, rx_deq;
    logic           rxen_q, rxen_d;

    assign io_rx_valid = (rx_cnt_q != '0);
    assign io_rx_bits  = rx_mem[rx_rd_q];
    assign rx_enq      = io_link_rx_valid & rxen_q & (rx_cnt_q < RX_DEPTH);
    assign rx_deq      = io_rx_valid & io_rx_ready;

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (io_flush_rx) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_enq) rx_wr_d = rx_wr_q + RAW'(1);
            if (rx_deq) rx_rd_d = rx_rd_q + RAW'(1);
            case ({rx_enq, rx_deq})
                2'b10:   rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    // A frame leaving the TX side arms reception only for receive-direction
    // frames; the first returning word disarms it. Flush wins over both.
    always_comb begin
        rxen_d = rxen_q;
        if (io_flush_rx)           rxen_d = 1'b0;
        else if (fire_tx)          rxen_d = ~io_ctrl_fmt_iodir;
        else if (io_link_rx_valid) rxen_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            rxen_q   <= 1'b0;
        end else begin
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            rxen_q   <= rxen_d;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_enq) rx_mem[rx_wr_q] <= io_link_rx_bits;
    end

`ifdef N101_QSPI_FIFO_RXOVF_EN
    logic rx_drop;
    logic rx_ovf_q;

    assign rx_drop = io_link_rx_valid & rxen_q & (rx_cnt_q == RX_DEPTH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        rx_ovf_q <= 1'b0;
        else if (io_flush_rx) rx_ovf_q <= 1'b0;
        else if (rx_drop)     rx_ovf_q <= 1'b1;
    end

    assign io_rx_ovf = rx_ovf_q;
`else
    assign io_rx_ovf = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame length, chip select, lock and watermarks
    // ------------------------------------------------------------------
    logic [LW+1:0] len_ext, cnt_full;

    assign len_ext = {2'b00, io_ctrl_fmt_len};

    // Shifter cycles = bits per frame divided by lanes, rounded up.
    always_comb begin
        cnt_full = '0;
        case (io_ctrl_fmt_proto)
            2'd0:    cnt_full = len_ext;
            2'd1:    cnt_full = (len_ext + (LW+2)'(1)) >> 1;
            2'd2:    cnt_full = (len_ext + (LW+2)'(3)) >> 2;
            default: cnt_full = '0;
        endcase
    end

    assign io_link_cnt = cnt_full[LW-1:0];

    logic [1:0] cs_mode_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cs_mode_q <= 2'd0;
        else          cs_mode_q <= io_ctrl_cs_mode;
    end

    assign io_link_cs_set   = (cs_mode_q != 2'd3);
    assign io_link_cs_clear = (cs_mode_q != io_ctrl_cs_mode)
                            | (fire_tx & (cs_mode_q < 2'd2));
    assign io_link_lock     = io_link_tx_valid | rxen_q;

    assign io_ip_txwm = (32'(tx_cnt_q) < 32'(io_ctrl_wm_tx));
    assign io_ip_rxwm = (32'(rx_cnt_q) > 32'(io_ctrl_wm_rx));

endmodule
